// File: rtl/eth_rx_frame_fifo_if.sv
// Byte-wide AXI-Stream bundle used on both sides of the RX frame FIFO.
// master drives data/valid/last/user; slave drives ready.
interface eth_rx_frame_fifo_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        input  tready,
        output tlast,
        output tuser
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready,
        input  tlast,
        input  tuser
    );
endinterface

// File: rtl/eth_rx_frame_fifo.sv
// Store-and-forward Ethernet RX frame buffer (clock125 domain).
// Frames are written speculatively into a circular RAM and only become readable once their
// last byte arrives clean; bad (tuser) or overflowing frames are rolled back whole.
// Optional: define ETH_RX_FIFO_RUNT_FILTER_EN to also roll back frames shorter than 60 bytes.
module eth_rx_frame_fifo #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                clock125,
    input  logic                reset,
    eth_rx_frame_fifo_if.slave  s_axis,
    eth_rx_frame_fifo_if.master m_axis,
    output logic [CNT_W-1:0]    drop_bad_count,
    output logic [CNT_W-1:0]    drop_ovf_count,
    output logic                frame_avail
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef logic [ADDR_W:0] ptr_t;
    typedef enum logic [1:0] {StIdle, StRecv, StDrop} wr_state_e;

    localparam ptr_t             PtrOne = ptr_t'(1);
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [8:0] mem_q [DEPTH];

    wr_state_e        state_q, state_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    ptr_t             wr_commit_q, wr_commit_d;
    ptr_t             commit_rd_q;
    ptr_t             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] bad_cnt_q, bad_cnt_d;
    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [8:0]       out_word_q, out_word_d;

    logic mem_we;
    logic full;
    logic runt;
    logic bad_inc;
    logic ovf_inc;
    logic load;

`ifdef ETH_RX_FIFO_RUNT_FILTER_EN
    logic [6:0] len_q, len_d;

    // Per-frame byte count of bytes already written; saturates at 127.
    always_comb begin
        len_d = len_q;
        if (state_d == StIdle) begin
            len_d = '0;
        end else if (mem_we && (len_q != 7'h7f)) begin
            len_d = len_q + 7'd1;
        end
    end

    // Length register for the runt check.
    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    // Current tlast byte makes the frame len_q + 1 long.
    assign runt = (len_q < 7'd59);
`else
    assign runt = 1'b0;
`endif

    assign full = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                  (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

    // Write FSM: speculative write, commit on clean tlast, roll back on bad/overflow.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        mem_we      = 1'b0;
        bad_inc     = 1'b0;
        ovf_inc     = 1'b0;
        if (s_axis.tvalid) begin
            unique case (state_q)
                StIdle, StRecv: begin
                    if (full) begin
                        wr_ptr_d = wr_commit_q;
                        if (s_axis.tlast) begin
                            ovf_inc = 1'b1;
                            state_d = StIdle;
                        end else begin
                            // Overflow is counted once, when DROP sees the tlast.
                            state_d = StDrop;
                        end
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + PtrOne;
                        if (s_axis.tlast) begin
                            state_d = StIdle;
                            if (s_axis.tuser || runt) begin
                                wr_ptr_d = wr_commit_q;
                                bad_inc  = 1'b1;
                            end else begin
                                wr_commit_d = wr_ptr_q + PtrOne;
                            end
                        end else begin
                            state_d = StRecv;
                        end
                    end
                end
                StDrop: begin
                    if (s_axis.tlast) begin
                        ovf_inc = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Saturating drop counters.
    always_comb begin
        bad_cnt_d = (bad_inc && !(&bad_cnt_q)) ? bad_cnt_q + CntOne : bad_cnt_q;
        ovf_cnt_d = (ovf_inc && !(&ovf_cnt_q)) ? ovf_cnt_q + CntOne : ovf_cnt_q;
    end

    // Output register load; the read side sees commits one cycle late so a freshly written
    // byte is never read in the cycle it is written.
    always_comb begin
        load        = (rd_ptr_q != commit_rd_q) && (!out_valid_q || m_axis.tready);
        rd_ptr_d    = rd_ptr_q;
        out_word_d  = out_word_q;
        out_valid_d = out_valid_q && !m_axis.tready;
        if (load) begin
            rd_ptr_d    = rd_ptr_q + PtrOne;
            out_word_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
            out_valid_d = 1'b1;
        end
    end

    // Frame RAM, {tlast, data} per entry; no reset needed.
    always_ff @(posedge clock125) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= {s_axis.tlast, s_axis.tdata};
        end
    end

    // State, pointers, counters and output register.
    always_ff @(posedge clock125 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            wr_commit_q <= '0;
            commit_rd_q <= '0;
            rd_ptr_q    <= '0;
            bad_cnt_q   <= '0;
            ovf_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            wr_commit_q <= wr_commit_d;
            commit_rd_q <= wr_commit_q;
            rd_ptr_q    <= rd_ptr_d;
            bad_cnt_q   <= bad_cnt_d;
            ovf_cnt_q   <= ovf_cnt_d;
            out_valid_q <= out_valid_d;
            out_word_q  <= out_word_d;
        end
    end

    assign s_axis.tready  = 1'b1;
    assign m_axis.tvalid  = out_valid_q;
    assign m_axis.tdata   = out_word_q[7:0];
    assign m_axis.tlast   = out_word_q[8];
    assign m_axis.tuser   = 1'b0;
    assign drop_bad_count = bad_cnt_q;
    assign drop_ovf_count = ovf_cnt_q;
    assign frame_avail    = (rd_ptr_q != wr_commit_q) || out_valid_q;
endmodule

// File: tb/tb_eth_rx_frame_fifo.sv
// Self-checking bench for eth_rx_frame_fifo: directed frames plus a randomised run, checked
// against a queue of the bytes of every frame that should be committed.
module tb_eth_rx_frame_fifo;
    localparam int unsigned AW    = 11;
    localparam int unsigned CW    = 16;
    localparam int          Depth = 1 << AW;
    localparam int          NFr   = 40;
`ifdef ETH_RX_FIFO_RUNT_FILTER_EN
    localparam bit RuntEn = 1'b1;
`else
    localparam bit RuntEn = 1'b0;
`endif

    logic          clock125 = 1'b0;
    logic          reset    = 1'b1;
    logic [CW-1:0] drop_bad_count;
    logic [CW-1:0] drop_ovf_count;
    logic          frame_avail;

    eth_rx_frame_fifo_if s_if ();
    eth_rx_frame_fifo_if m_if ();

    eth_rx_frame_fifo #(
        .ADDR_W(AW),
        .CNT_W (CW)
    ) dut (
        .clock125      (clock125),
        .reset         (reset),
        .s_axis        (s_if),
        .m_axis        (m_if),
        .drop_bad_count(drop_bad_count),
        .drop_ovf_count(drop_ovf_count),
        .frame_avail   (frame_avail)
    );

    always #4 clock125 = ~clock125;

    int         checks    = 0;
    int         errors    = 0;
    logic [8:0] exp_q[$];
    int         exp_bad   = 0;
    int         exp_ovf   = 0;
    int         committed = 0;
    int         consumed  = 0;
    int         lens[NFr];
    bit         bads[NFr];
    int         good_total;
    int         w;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one frame byte per cycle; good frames are appended to the expected stream.
    task automatic send_frame(input int len, input bit bad, input bit commit);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            @(negedge clock125);
            s_if.tvalid = 1'b1;
            s_if.tdata  = b;
            s_if.tlast  = (i == len - 1);
            s_if.tuser  = bad && (i == len - 1);
            if (commit) exp_q.push_back({(i == len - 1), b});
        end
        @(negedge clock125);
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        if (commit) committed += len;
    endtask

    // Consumes n bytes with random tready, checking order, tlast and hold-while-stalled.
    task automatic drain(input int n, input int pct, input int budget, input string tag);
        int         got = 0;
        int         cyc = 0;
        bit         stalled = 1'b0;
        logic [8:0] held = '0;
        logic [8:0] e;
        while (got < n && cyc < budget) begin
            @(negedge clock125);
            cyc++;
            if (stalled) begin
                chk({tag, " hold valid"}, 32'(m_if.tvalid), 32'd1);
                chk({tag, " hold word"}, 32'({m_if.tlast, m_if.tdata}), 32'(held));
            end
            m_if.tready = ($urandom_range(99) < pct);
            stalled = m_if.tvalid && !m_if.tready;
            held = {m_if.tlast, m_if.tdata};
            if (m_if.tvalid && m_if.tready) begin
                got++;
                consumed++;
                if (exp_q.size() == 0) begin
                    chk({tag, " unexpected byte"}, 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk({tag, " word"}, 32'({m_if.tlast, m_if.tdata}), 32'(e));
                end
            end
        end
        chk({tag, " byte count"}, 32'(got), 32'(n));
        @(negedge clock125);
        m_if.tready = 1'b0;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, " drop_bad"}, 32'(drop_bad_count), 32'(exp_bad));
        chk({tag, " drop_ovf"}, 32'(drop_ovf_count), 32'(exp_ovf));
    endtask

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tlast  = 1'b0;
        s_if.tuser  = 1'b0;
        m_if.tready = 1'b0;

        // Reset state
        #1;
        chk("rst tvalid", 32'(m_if.tvalid), 32'd0);
        chk("rst tdata", 32'(m_if.tdata), 32'd0);
        chk("rst tlast", 32'(m_if.tlast), 32'd0);
        chk("rst frame_avail", 32'(frame_avail), 32'd0);
        chk("rst s_tready", 32'(s_if.tready), 32'd1);
        chk_counts("rst");
        repeat (3) @(negedge clock125);
        reset = 1'b0;
        @(negedge clock125);

        // T1: 64-byte good frame, tvalid two edges after the tlast edge
        send_frame(64, 1'b0, 1'b1);
        chk("t1 tvalid after E0", 32'(m_if.tvalid), 32'd0);
        chk("t1 frame_avail after E0", 32'(frame_avail), 32'd1);
        @(negedge clock125);
        chk("t1 tvalid after E1", 32'(m_if.tvalid), 32'd0);
        @(negedge clock125);
        chk("t1 tvalid after E2", 32'(m_if.tvalid), 32'd1);
        chk("t1 first word", 32'({m_if.tlast, m_if.tdata}), 32'(exp_q[0]));
        drain(64, 100, 500, "t1");
        chk_counts("t1");
        chk("t1 frame_avail end", 32'(frame_avail), 32'd0);

        // T2: bad 100-byte frame then good 64-byte frame
        send_frame(100, 1'b1, 1'b0);
        exp_bad++;
        send_frame(64, 1'b0, 1'b1);
        drain(64, 100, 500, "t2");
        chk_counts("t2");
        chk("t2 frame_avail end", 32'(frame_avail), 32'd0);

        // T3: three 1000-byte frames into a stalled consumer; the third overflows
        send_frame(1000, 1'b0, 1'b1);
        send_frame(1000, 1'b0, 1'b1);
        send_frame(1000, 1'b0, 1'b0);
        exp_ovf++;
        chk_counts("t3");
        chk("t3 frame_avail", 32'(frame_avail), 32'd1);
        drain(2000, 100, 3000, "t3");
        repeat (3) @(negedge clock125);
        chk("t3 tvalid end", 32'(m_if.tvalid), 32'd0);
        chk("t3 frame_avail end", 32'(frame_avail), 32'd0);

        // T4: random lengths, occasional bad frames, random tready, many pointer wraps
        good_total = 0;
        for (int k = 0; k < NFr; k++) begin
            lens[k] = 60 + int'($urandom_range(1454));
            bads[k] = ($urandom_range(7) == 0);
            if (!bads[k]) good_total += lens[k];
        end
        fork
            begin
                for (int k = 0; k < NFr; k++) begin
                    w = 0;
                    while ((committed - consumed + lens[k] > Depth - 2) && w < 20000) begin
                        @(negedge clock125);
                        w++;
                    end
                    chk("t4 space wait", 32'(w < 20000), 32'd1);
                    send_frame(lens[k], bads[k], !bads[k]);
                    if (bads[k]) exp_bad++;
                end
            end
            drain(good_total, 80, 80000, "t4");
        join
        chk_counts("t4");
        chk("t4 leftover", 32'(exp_q.size()), 32'd0);

        // T6: runt filter boundary, 59 vs 60 bytes
        send_frame(59, 1'b0, !RuntEn);
        if (RuntEn) exp_bad++;
        send_frame(60, 1'b0, 1'b1);
        drain(RuntEn ? 60 : 119, 100, 1000, "t6");
        chk_counts("t6");

        // T5: reset mid-frame with 300 committed bytes buffered
        send_frame(300, 1'b0, 1'b1);
        for (int i = 0; i < 50; i++) begin
            @(negedge clock125);
            s_if.tvalid = 1'b1;
            s_if.tdata  = 8'($urandom);
            s_if.tlast  = 1'b0;
        end
        @(negedge clock125);
        reset       = 1'b1;
        s_if.tvalid = 1'b0;
        #1;
        exp_q.delete();
        exp_bad   = 0;
        exp_ovf   = 0;
        committed = 0;
        consumed  = 0;
        chk("t5 tvalid", 32'(m_if.tvalid), 32'd0);
        chk("t5 tdata", 32'(m_if.tdata), 32'd0);
        chk("t5 tlast", 32'(m_if.tlast), 32'd0);
        chk("t5 frame_avail", 32'(frame_avail), 32'd0);
        chk("t5 s_tready", 32'(s_if.tready), 32'd1);
        chk_counts("t5 rst");
        @(negedge clock125);
        reset = 1'b0;
        send_frame(64, 1'b0, 1'b1);
        drain(64, 100, 500, "t5");
        chk_counts("t5");
        chk("t5 frame_avail end", 32'(frame_avail), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
